// File: rtl/osd_ctm_mt_package.sv
// Shared types for the multi-hart mriscv control-transfer trace adapter:
// trace port record, buffered entry record and filter mode encodings.
package osd_ctm_mt_package;

    localparam int CTM_ADDR_W = 32;
    localparam int CTM_TIME_W = 32;

    typedef enum logic [1:0] {
        CTM_MODE_ALL   = 2'd0,
        CTM_MODE_JUMPS = 2'd1,
        CTM_MODE_JR    = 2'd2,
        CTM_MODE_OFF   = 2'd3
    } ctm_mode_e;

    typedef struct packed {
        logic                  valid;
        logic [CTM_ADDR_W-1:0] pc;
        logic [CTM_ADDR_W-1:0] jbtarget;
        logic                  jal;
        logic                  jr;
    } mriscv_trace_exec_t;

    // Narrower ADDR/TIME configurations store their values zero-extended.
    typedef struct packed {
        logic                  overflow;
        logic [CTM_ADDR_W-1:0] pc;
        logic [CTM_ADDR_W-1:0] npc;
        logic                  jal;
        logic                  jalr;
        logic [CTM_TIME_W-1:0] timestamp;
    } ctm_trace_entry_t;

    function automatic logic ctm_filter_pass(logic [1:0] mode, logic jal, logic jr);
        logic pass;
        case (ctm_mode_e'(mode))
            CTM_MODE_ALL:   pass = 1'b1;
            CTM_MODE_JUMPS: pass = jal | jr;
            CTM_MODE_JR:    pass = jr;
            default:        pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/osd_ctm_trace_fifo.sv
// Per-hart synchronous FIFO of trace entries. Full/empty reflect the state
// before this cycle's push/pop, so a full FIFO never accepts a write-through.
module osd_ctm_trace_fifo
    import osd_ctm_mt_package::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  ctm_trace_entry_t push_data,
    input  logic             pop,
    output ctm_trace_entry_t head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    ctm_trace_entry_t mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/osd_ctm_mriscv_mt.sv
// Multi-hart trace adapter: filters and timestamps control transfers per hart,
// buffers them with lost-event markers and merges them round-robin into one stream.
module osd_ctm_mriscv_mt
    import osd_ctm_mt_package::*;
#(
    parameter  int NUM_HARTS  = 2,
    parameter  int FIFO_DEPTH = 4,
    parameter  int ADDR_WIDTH = 32,
    parameter  int TIME_WIDTH = 32,
    parameter  int LOST_WIDTH = 16,
    localparam int HART_W     = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [1:0]                         mode,
    input  mriscv_trace_exec_t [NUM_HARTS-1:0] trace_port,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [HART_W-1:0]                  out_hart,
    output logic                               out_overflow,
    output logic [ADDR_WIDTH-1:0]              out_pc,
    output logic [ADDR_WIDTH-1:0]              out_npc,
    output logic                               out_jal,
    output logic                               out_jalr,
    output logic [TIME_WIDTH-1:0]              out_time,
    output logic                               lost_any
);

    if (LOST_WIDTH > ADDR_WIDTH) begin : g_check_lost_width
        $error("LOST_WIDTH must not exceed ADDR_WIDTH");
    end
    if (ADDR_WIDTH > CTM_ADDR_W || TIME_WIDTH > CTM_TIME_W) begin : g_check_entry_width
        $error("ADDR_WIDTH/TIME_WIDTH exceed the trace entry field widths");
    end
    if (NUM_HARTS < 1 || NUM_HARTS > 8) begin : g_check_harts
        $error("NUM_HARTS must be within 1..8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_check_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [TIME_WIDTH-1:0] timestamp;
    logic [NUM_HARTS-1:0]  fifo_empty;
    logic [NUM_HARTS-1:0]  fifo_pop;
    logic [NUM_HARTS-1:0]  lost_nonzero;
    ctm_trace_entry_t      fifo_head [NUM_HARTS];
    logic                  grant_valid;
    logic [HART_W-1:0]     grant_idx;
    logic [HART_W-1:0]     rr_ptr;
    ctm_trace_entry_t      grant_entry;
    logic                  load_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timestamp <= '0;
        end else begin
            timestamp <= timestamp + 1'b1;
        end
    end

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic                  pass;
        logic                  full;
        logic                  push;
        logic [LOST_WIDTH-1:0] lost;
        ctm_trace_entry_t      push_data;

        assign pass = trace_port[h].valid & enable
                    & ctm_filter_pass(mode, trace_port[h].jal, trace_port[h].jr);

        // A pending lost count always wins the free slot over a new event.
        always_comb begin
            push                = 1'b0;
            push_data           = '0;
            push_data.timestamp = CTM_TIME_W'(timestamp);
            if (lost != '0 && !full) begin
                push               = 1'b1;
                push_data.overflow = 1'b1;
                push_data.pc       = CTM_ADDR_W'(lost);
            end else if (pass && !full) begin
                push           = 1'b1;
                push_data.pc   = CTM_ADDR_W'(trace_port[h].pc[ADDR_WIDTH-1:0]);
                push_data.npc  = CTM_ADDR_W'(trace_port[h].jbtarget[ADDR_WIDTH-1:0]);
                push_data.jal  = trace_port[h].jal;
                push_data.jalr = trace_port[h].jr;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                lost <= '0;
            end else if (lost != '0 && !full) begin
                lost <= pass ? LOST_WIDTH'(1) : '0;
            end else if (pass && full && lost != '1) begin
                lost <= lost + 1'b1;
            end
        end

        assign lost_nonzero[h] = (lost != '0);
        assign fifo_pop[h]     = load_out && (grant_idx == HART_W'(h));

        osd_ctm_trace_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push),
            .push_data (push_data),
            .pop       (fifo_pop[h]),
            .head      (fifo_head[h]),
            .full      (full),
            .empty     (fifo_empty[h])
        );
    end

    // First non-empty FIFO at or after the round-robin pointer, with wrap.
    always_comb begin
        int cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_HARTS;
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = HART_W'(cand);
            end
        end
    end

    assign grant_entry = fifo_head[grant_idx];
    assign load_out    = grant_valid && (!out_valid || out_ready);
    assign lost_any    = |lost_nonzero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_hart     <= '0;
            out_overflow <= 1'b0;
            out_pc       <= '0;
            out_npc      <= '0;
            out_jal      <= 1'b0;
            out_jalr     <= 1'b0;
            out_time     <= '0;
            rr_ptr       <= '0;
        end else if (load_out) begin
            out_valid    <= 1'b1;
            out_hart     <= grant_idx;
            out_overflow <= grant_entry.overflow;
            out_pc       <= grant_entry.pc[ADDR_WIDTH-1:0];
            out_npc      <= grant_entry.npc[ADDR_WIDTH-1:0];
            out_jal      <= grant_entry.jal;
            out_jalr     <= grant_entry.jalr;
            out_time     <= grant_entry.timestamp[TIME_WIDTH-1:0];
            rr_ptr       <= HART_W'((int'(grant_idx) + 1) % NUM_HARTS);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Upper bits beyond narrower configured widths are carried but never observed.
    logic unused_wide_bits;
    assign unused_wide_bits = ^{grant_entry.timestamp, grant_entry.pc, grant_entry.npc, trace_port};

endmodule

// File: tb/tb_osd_ctm_mriscv_mt.sv
// Self-checking bench for osd_ctm_mriscv_mt: queue-based reference model,
// filter vector table, directed multi-cycle sequences and randomized traffic.
module tb_osd_ctm_mriscv_mt;
    import osd_ctm_mt_package::*;

    localparam int NH    = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int TW    = 8;
    localparam int LW    = 3;
    localparam int HW    = 1;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        enable = 1'b0;
    logic [1:0]                  mode = 2'd0;
    logic                        out_ready = 1'b0;
    mriscv_trace_exec_t [NH-1:0] trace_port = '0;
    logic                        out_valid;
    logic [HW-1:0]               out_hart;
    logic                        out_overflow;
    logic [AW-1:0]               out_pc;
    logic [AW-1:0]               out_npc;
    logic                        out_jal;
    logic                        out_jalr;
    logic [TW-1:0]               out_time;
    logic                        lost_any;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    osd_ctm_mriscv_mt #(
        .NUM_HARTS  (NH),
        .FIFO_DEPTH (DEPTH),
        .ADDR_WIDTH (AW),
        .TIME_WIDTH (TW),
        .LOST_WIDTH (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .trace_port   (trace_port),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_hart     (out_hart),
        .out_overflow (out_overflow),
        .out_pc       (out_pc),
        .out_npc      (out_npc),
        .out_jal      (out_jal),
        .out_jalr     (out_jalr),
        .out_time     (out_time),
        .lost_any     (lost_any)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          ovf;
        logic [31:0]   pc;
        logic [31:0]   npc;
        logic          jal;
        logic          jr;
        logic [TW-1:0] t;
    } mentry_t;

    mentry_t mq [NH][$];
    int      mlost [NH] = '{default: 0};
    int      mrr = 0;
    int      mts = 0;
    bit      mvalid = 1'b0;
    int      mhart = 0;
    mentry_t mout = '0;

    function automatic bit passes(logic [1:0] m, bit en, bit v, bit jal, bit jr);
        if (!v || !en) return 1'b0;
        case (m)
            2'd0:    return 1'b1;
            2'd1:    return jal || jr;
            2'd2:    return jr;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        bit      full_pre [NH];
        bit      p;
        int      g;
        mentry_t e;
        if (!rst) begin
            for (int h = 0; h < NH; h++) begin
                mq[h].delete();
                mlost[h] = 0;
            end
            mrr = 0;
            mts = 0;
            mvalid = 1'b0;
        end else begin
            for (int h = 0; h < NH; h++) full_pre[h] = (mq[h].size() >= DEPTH);
            if (!mvalid || out_ready) begin
                g = -1;
                for (int i = 0; i < NH; i++)
                    if (g < 0 && mq[(mrr + i) % NH].size() > 0) g = (mrr + i) % NH;
                if (g >= 0) begin
                    mout   = mq[g].pop_front();
                    mhart  = g;
                    mvalid = 1'b1;
                    mrr    = (g + 1) % NH;
                end else begin
                    mvalid = 1'b0;
                end
            end
            for (int h = 0; h < NH; h++) begin
                p = passes(mode, enable, trace_port[h].valid, trace_port[h].jal, trace_port[h].jr);
                if (mlost[h] > 0 && !full_pre[h]) begin
                    e = '{ovf: 1'b1, pc: 32'(mlost[h]), npc: 32'd0, jal: 1'b0, jr: 1'b0, t: TW'(mts)};
                    mq[h].push_back(e);
                    mlost[h] = p ? 1 : 0;
                end else if (p && !full_pre[h]) begin
                    e = '{ovf: 1'b0, pc: trace_port[h].pc, npc: trace_port[h].jbtarget,
                          jal: trace_port[h].jal, jr: trace_port[h].jr, t: TW'(mts)};
                    mq[h].push_back(e);
                end else if (p) begin
                    mlost[h] = (mlost[h] + 1 > (1 << LW) - 1) ? (1 << LW) - 1 : mlost[h] + 1;
                end
            end
            mts = (mts + 1) % (1 << TW);
        end
    end

    // ---------------- accepted-entry log ----------------
    typedef struct packed {
        logic [HW-1:0] hart;
        logic          ovf;
        logic [31:0]   pc;
        logic [31:0]   npc;
        logic          jal;
        logic          jalr;
    } acc_t;

    acc_t acc_q [$];

    function automatic acc_t mk_acc(int hart, bit ovf, logic [31:0] pc, logic [31:0] npc, bit jal, bit jalr);
        acc_t a;
        a.hart = HW'(hart);
        a.ovf  = ovf;
        a.pc   = pc;
        a.npc  = npc;
        a.jal  = jal;
        a.jalr = jalr;
        return a;
    endfunction

    // ---------------- check helpers ----------------
    task automatic checkValue(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic [HW+1+32+32+1+1+TW-1:0] got_f;
        logic [HW+1+32+32+1+1+TW-1:0] exp_f;
        bit any_lost;
        any_lost = 1'b0;
        for (int h = 0; h < NH; h++) if (mlost[h] != 0) any_lost = 1'b1;
        checkValue("model_out_valid", 128'(out_valid), 128'(mvalid));
        checkValue("model_lost_any", 128'(lost_any), 128'(any_lost));
        if (mvalid) begin
            got_f = {out_hart, out_overflow, out_pc, out_npc, out_jal, out_jalr, out_time};
            exp_f = {HW'(mhart), mout.ovf, mout.pc, mout.npc, mout.jal, mout.jr, mout.t};
            checkValue("model_out_fields", 128'(got_f), 128'(exp_f));
        end
    endtask

    task automatic checkAccepted(string name, int idx, acc_t exp);
        acc_t got;
        got = (idx < acc_q.size()) ? acc_q[idx] : '1;
        checkValue(name, 128'(got), 128'(exp));
    endtask

    task automatic applyStimulus(int h, bit v, logic [31:0] pc, logic [31:0] npc, bit jal, bit jr);
        trace_port[h].valid    = v;
        trace_port[h].pc       = pc;
        trace_port[h].jbtarget = npc;
        trace_port[h].jal      = jal;
        trace_port[h].jr       = jr;
    endtask

    task automatic clearTrace();
        trace_port = '0;
    endtask

    // One clock: log an acceptance, cross the edge, compare on the falling edge.
    task automatic tick();
        if (out_valid && out_ready)
            acc_q.push_back(mk_acc(int'(out_hart), out_overflow, out_pc, out_npc, out_jal, out_jalr));
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(int n);
        clearTrace();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doReset();
        clearTrace();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        acc_q.delete();
    endtask

    // ---------------- filter vector table ----------------
    typedef struct packed {
        logic [1:0] mode;
        bit         en;
        bit         v;
        bit         jal;
        bit         jr;
        bit         exp_pass;
    } fvec_t;

    fvec_t fvecs [10];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stall;
        fvecs[0] = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        fvecs[1] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        fvecs[2] = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        fvecs[3] = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        fvecs[4] = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        fvecs[5] = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        fvecs[6] = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        fvecs[7] = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        fvecs[8] = '{2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        fvecs[9] = '{2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state: every output low while rst is asserted.
        @(negedge clk);
        checkValue("reset_outputs",
                   128'({out_valid, out_hart, out_overflow, out_pc, out_npc, out_jal, out_jalr, out_time, lost_any}),
                   128'(0));
        checkOutput();
        rst = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        idle(2);

        // Filter table: one event on hart0 per vector, count what emerges.
        for (int i = 0; i < 10; i++) begin
            mode   = fvecs[i].mode;
            enable = fvecs[i].en;
            acc_q.delete();
            applyStimulus(0, fvecs[i].v, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), fvecs[i].jal, fvecs[i].jr);
            tick();
            idle(4);
            checkValue($sformatf("filter_count_%0d", i), 128'(acc_q.size()), 128'(fvecs[i].exp_pass));
            if (fvecs[i].exp_pass)
                checkAccepted($sformatf("filter_entry_%0d", i), 0,
                              mk_acc(0, 1'b0, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), fvecs[i].jal, fvecs[i].jr));
        end
        enable = 1'b1;

        // Jumps-only filter: a plain retirement then a jal.
        mode = 2'd1;
        acc_q.delete();
        applyStimulus(0, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 1'b1, 32'h104, 32'h200, 1'b1, 1'b0);
        tick();
        idle(4);
        checkValue("jumps_only_count", 128'(acc_q.size()), 128'(1));
        checkAccepted("jumps_only_entry", 0, mk_acc(0, 1'b0, 32'h104, 32'h200, 1'b1, 1'b0));
        mode = 2'd0;

        // Reset mid-stream with hart0 holding buffered entries.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1'b1, 32'h700 + 32'(k * 4), 32'h780, 1'b0, 1'b0);
            tick();
        end
        clearTrace();
        rst = 1'b0;
        #1;
        checkValue("midreset_out_valid", 128'(out_valid), 128'(0));
        checkValue("midreset_lost_any", 128'(lost_any), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        applyStimulus(0, 1'b1, 32'h800, 32'h880, 1'b1, 1'b0);
        tick();
        clearTrace();
        tick();
        checkValue("post_reset_valid", 128'(out_valid), 128'(1));
        checkValue("post_reset_time", 128'(out_time), 128'(2));
        checkValue("post_reset_pc", 128'(out_pc), 128'(32'h800));

        // Round-robin: both harts push two jumps on the same cycles.
        doReset();
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 1'b1, 32'h10 + 32'(k), 32'h90, 1'b1, 1'b0);
            applyStimulus(1, 1'b1, 32'h20 + 32'(k), 32'hA0, 1'b1, 1'b0);
            tick();
        end
        idle(6);
        checkValue("rr_count", 128'(acc_q.size()), 128'(4));
        for (int k = 0; k < 4; k++)
            checkValue($sformatf("rr_hart_%0d", k), 128'(acc_q.size() > k ? acc_q[k].hart : 1'bx), 128'(k % 2));

        // Overflow: hart0 entry parked in the output register, hart1 sends 7.
        doReset();
        out_ready = 1'b0;
        applyStimulus(0, 1'b1, 32'h500, 32'h600, 1'b1, 1'b0);
        tick();
        idle(1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1, 1'b1, 32'h3000 + 32'(k * 4), 32'h3100 + 32'(k), 1'b0, 1'b0);
            tick();
            checkValue("stall_hold_pc", 128'(out_pc), 128'(32'h500));
        end
        checkValue("overflow_lost_any", 128'(lost_any), 128'(1));
        out_ready = 1'b1;
        idle(10);
        checkValue("overflow_count", 128'(acc_q.size()), 128'(6));
        checkAccepted("overflow_first", 0, mk_acc(0, 1'b0, 32'h500, 32'h600, 1'b1, 1'b0));
        for (int k = 0; k < 4; k++)
            checkAccepted($sformatf("overflow_kept_%0d", k), k + 1,
                          mk_acc(1, 1'b0, 32'h3000 + 32'(k * 4), 32'h3100 + 32'(k), 1'b0, 1'b0));
        checkAccepted("overflow_marker", 5, mk_acc(1, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0));
        checkValue("overflow_lost_clear", 128'(lost_any), 128'(0));

        // Collision: a passing event arrives as a slot frees while lost=2.
        doReset();
        out_ready = 1'b0;
        applyStimulus(0, 1'b1, 32'h500, 32'h600, 1'b1, 1'b0);
        tick();
        idle(1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 1'b1, 32'h4000 + 32'(k * 4), 32'h4100, 1'b0, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        applyStimulus(1, 1'b1, 32'h4018, 32'h4100, 1'b0, 1'b0);
        tick();
        checkValue("collision_lost_any", 128'(lost_any), 128'(1));
        out_ready = 1'b1;
        enable = 1'b0;
        idle(12);
        checkValue("collision_count", 128'(acc_q.size()), 128'(7));
        checkAccepted("collision_marker_2", 5, mk_acc(1, 1'b1, 32'd2, 32'd0, 1'b0, 1'b0));
        checkAccepted("collision_marker_1", 6, mk_acc(1, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0));
        enable = 1'b1;

        // Randomized traffic with bursty backpressure; timestamp wraps several times.
        stall = 0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 9) != 0);
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 29) == 0) begin
                stall = $urandom_range(5, 20);
                out_ready = 1'b0;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            for (int h = 0; h < NH; h++)
                applyStimulus(h, $urandom_range(0, 9) < 6, $urandom, $urandom,
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end
        out_ready = 1'b1;
        idle(30);
        checkValue("final_drained", 128'(out_valid), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
